vram_dp: RTL and testbench



---
 rtl/vram_dp.sv | 153 +++++++++++++++
 tb/tb_vram_dp.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_dp.sv
// Dual-port video RAM: port A is masked random access with read-first semantics.
// Port B streams bursts through a 2-entry skid buffer over valid/ready.
module vram_dp #(
    parameter int DATA_WIDTH = 16,
    parameter int LANE_WIDTH = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                             clk,
    input  logic                             reset_i,
    input  logic                             a_sel_i,
    input  logic                             a_wr_en_i,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] a_wr_mask_i,
    input  logic [ADDR_WIDTH-1:0]            a_address_i,
    input  logic [DATA_WIDTH-1:0]            a_data_i,
    output logic [DATA_WIDTH-1:0]            a_data_o,
    input  logic                             b_start_i,
    input  logic [ADDR_WIDTH-1:0]            b_address_i,
    input  logic [LEN_WIDTH-1:0]             b_len_i,
    output logic                             b_busy_o,
    output logic [DATA_WIDTH-1:0]            b_data_o,
    output logic                             b_valid_o,
    input  logic                             b_ready_i,
    output logic                             b_done_o
);
    localparam int MASK_WIDTH = DATA_WIDTH / LANE_WIDTH;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] a_data_q, b_rd_q;

    logic                  issue, pop;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [2:0]            occ;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        count_d    = count_q;
        ent0_d     = ent0_q;
        ent1_d     = ent1_q;
        done_d     = 1'b0;
        issue      = 1'b0;
        rd_addr    = addr_q;
        pop        = (count_q != 2'd0) && b_ready_i;
        // Occupancy after this cycle's pop; keeps the buffer at <= 2 while allowing 1 beat/cycle.
        occ        = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};

        case (state_q)
            S_IDLE: begin
                // The first read issues in the start cycle so data lands two cycles later.
                if (b_start_i && b_len_i != '0) begin
                    issue    = 1'b1;
                    rd_addr  = b_address_i;
                    addr_d   = b_address_i + 1'b1;
                    remain_d = b_len_i - 1'b1;
                    state_d  = S_RUN;
                end
            end
            default: begin
                if (remain_q != '0 && occ < 3'd2) begin
                    issue    = 1'b1;
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                end
                if (remain_q == '0 && !inflight_q && count_q == 2'd1 && pop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
        inflight_d = issue;

        case ({inflight_q, pop})
            2'b10: begin
                if (count_q == 2'd0) ent0_d = b_rd_q;
                else                 ent1_d = b_rd_q;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                ent0_d  = ent1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    ent0_d = b_rd_q;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = b_rd_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            ent0_q     <= '0;
            ent1_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            done_q     <= done_d;
        end
    end

    // Storage: reads and writes are non-blocking, so both ports see pre-write data.
    always_ff @(posedge clk) begin
        if (a_sel_i && a_wr_en_i) begin
            for (int k = 0; k < MASK_WIDTH; k++) begin
                if (a_wr_mask_i[k])
                    mem[a_address_i][k*LANE_WIDTH +: LANE_WIDTH] <= a_data_i[k*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            a_data_q <= '0;
            b_rd_q   <= '0;
        end else begin
            if (a_sel_i) a_data_q <= mem[a_address_i];
            if (issue)   b_rd_q   <= mem[rd_addr];
        end
    end

    assign a_data_o  = a_data_q;
    assign b_busy_o  = (state_q == S_RUN);
    assign b_valid_o = (count_q != 2'd0);
    assign b_data_o  = ent0_q;
    assign b_done_o  = done_q;
endmodule

// File: tb/tb_vram_dp.sv
// Directed bench for vram_dp: port A masking/read-first and port B burst streaming.
module tb_vram_dp;
    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        a_sel_i = 1'b0, a_wr_en_i = 1'b0;
    logic [3:0]  a_wr_mask_i = 4'h0;
    logic [15:0] a_address_i = '0, a_data_i = '0, a_data_o;
    logic        b_start_i = 1'b0;
    logic [15:0] b_address_i = '0;
    logic [9:0]  b_len_i = '0;
    logic        b_busy_o, b_valid_o, b_ready_i = 1'b0, b_done_o;
    logic [15:0] b_data_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] beats[$];
    int          cycs[$];
    int          done_cyc;
    int          stable_err;
    logic        busy_start, busy_at_done;

    vram_dp dut (
        .clk(clk), .reset_i(reset_i),
        .a_sel_i(a_sel_i), .a_wr_en_i(a_wr_en_i), .a_wr_mask_i(a_wr_mask_i),
        .a_address_i(a_address_i), .a_data_i(a_data_i), .a_data_o(a_data_o),
        .b_start_i(b_start_i), .b_address_i(b_address_i), .b_len_i(b_len_i),
        .b_busy_o(b_busy_o), .b_data_o(b_data_o), .b_valid_o(b_valid_o),
        .b_ready_i(b_ready_i), .b_done_o(b_done_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [15:0] addr, input logic [15:0] data, input logic [3:0] mask);
        a_sel_i = 1'b1; a_wr_en_i = 1'b1; a_address_i = addr; a_data_i = data; a_wr_mask_i = mask;
        tick();
        a_sel_i = 1'b0; a_wr_en_i = 1'b0;
    endtask

    task automatic a_read(input logic [15:0] addr);
        a_sel_i = 1'b1; a_wr_en_i = 1'b0; a_address_i = addr;
        tick();
        a_sel_i = 1'b0;
    endtask

    // Starts a burst and records accepted beats; returns while in the done cycle.
    task automatic burst(input logic [15:0] addr, input logic [9:0] len, input int mode);
        logic [3:0]  pat;
        logic        prev_stall;
        logic [15:0] prev_data;
        pat = 4'b1001;
        beats.delete(); cycs.delete();
        done_cyc = -1; stable_err = 0; busy_at_done = 1'b1;
        b_address_i = addr; b_len_i = len; b_start_i = 1'b1;
        tick();
        b_start_i = 1'b0;
        busy_start = b_busy_o;
        prev_stall = 1'b0; prev_data = '0;
        for (int c = 1; c <= 300; c++) begin
            b_ready_i = (mode == 0) ? 1'b1 : pat[(c-1)%4];
            if (prev_stall && (!b_valid_o || b_data_o !== prev_data)) stable_err++;
            if (b_done_o) begin
                done_cyc = c; busy_at_done = b_busy_o;
                break;
            end
            if (b_valid_o && b_ready_i) begin
                beats.push_back(b_data_o); cycs.push_back(c);
            end
            prev_stall = b_valid_o && !b_ready_i;
            prev_data  = b_data_o;
            tick();
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1; tick(); tick(); reset_i = 1'b0;
        checks++; if (a_data_o !== 16'h0) begin errors++; $display("FAIL reset_a_data got %h exp 0000", a_data_o); end
        checks++; if (b_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", b_busy_o); end
        checks++; if (b_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", b_valid_o); end
        checks++; if (b_data_o !== 16'h0) begin errors++; $display("FAIL reset_b_data got %h exp 0000", b_data_o); end
        checks++; if (b_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", b_done_o); end
    endtask

    task automatic test_masked_write();
        a_write(16'h0010, 16'hFFFF, 4'hF);
        a_write(16'h0010, 16'h1234, 4'b0101);
        a_read(16'h0010);
        checks++; if (a_data_o !== 16'hF2F4) begin errors++; $display("FAIL masked_write got %h exp F2F4", a_data_o); end
    endtask

    task automatic test_read_first();
        a_write(16'h0020, 16'hAAAA, 4'hF);
        a_sel_i = 1'b1; a_wr_en_i = 1'b1; a_wr_mask_i = 4'hF; a_address_i = 16'h0020; a_data_i = 16'h5555;
        tick();
        a_sel_i = 1'b0; a_wr_en_i = 1'b0;
        checks++; if (a_data_o !== 16'hAAAA) begin errors++; $display("FAIL read_first_old got %h exp AAAA", a_data_o); end
        a_read(16'h0020);
        checks++; if (a_data_o !== 16'h5555) begin errors++; $display("FAIL read_first_new got %h exp 5555", a_data_o); end
        // Deselected: output holds and the write enable alone must not store.
        a_wr_en_i = 1'b1; a_address_i = 16'h0010; a_data_i = 16'h0F0F;
        tick();
        a_wr_en_i = 1'b0;
        checks++; if (a_data_o !== 16'h5555) begin errors++; $display("FAIL desel_hold got %h exp 5555", a_data_o); end
        a_read(16'h0010);
        checks++; if (a_data_o !== 16'hF2F4) begin errors++; $display("FAIL desel_nowrite got %h exp F2F4", a_data_o); end
    endtask

    task automatic test_full_throughput();
        for (int i = 0; i < 8; i++) a_write(16'h0100 + 16'(i), 16'h0100 + 16'(i), 4'hF);
        burst(16'h0100, 10'd8, 0);
        checks++; if (busy_start !== 1'b1) begin errors++; $display("FAIL ft_busy got %b exp 1", busy_start); end
        checks++; if (beats.size() != 8) begin errors++; $display("FAIL ft_count got %0d exp 8", beats.size()); end
        for (int i = 0; i < beats.size() && i < 8; i++) begin
            checks++; if (beats[i] !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL ft_beat%0d got %h exp %h", i, beats[i], 16'h0100 + 16'(i)); end
            checks++; if (cycs[i] != 2 + i) begin errors++; $display("FAIL ft_cycle%0d got %0d exp %0d", i, cycs[i], 2 + i); end
        end
        checks++; if (done_cyc != 10) begin errors++; $display("FAIL ft_done_cycle got %0d exp 10", done_cyc); end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL ft_busy_at_done got %b exp 0", busy_at_done); end
        tick();
        checks++; if (b_done_o !== 1'b0) begin errors++; $display("FAIL ft_done_pulse got %b exp 0", b_done_o); end
    endtask

    task automatic test_backpressure();
        burst(16'h0100, 10'd8, 1);
        checks++; if (beats.size() != 8) begin errors++; $display("FAIL bp_count got %0d exp 8", beats.size()); end
        for (int i = 0; i < beats.size() && i < 8; i++) begin
            checks++; if (beats[i] !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL bp_beat%0d got %h exp %h", i, beats[i], 16'h0100 + 16'(i)); end
        end
        checks++; if (stable_err != 0) begin errors++; $display("FAIL bp_stable got %0d exp 0", stable_err); end
        checks++; if (done_cyc < 0) begin errors++; $display("FAIL bp_done got %0d exp >0", done_cyc); end
        b_ready_i = 1'b1;
        tick();
    endtask

    task automatic test_wrap_zero();
        logic [15:0] ad [4];
        logic [15:0] ex [4];
        int dones;
        ad = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        ex = '{16'h1FFE, 16'h1FFF, 16'hE000, 16'hE001};
        for (int i = 0; i < 4; i++) a_write(ad[i], ex[i], 4'hF);
        burst(16'hFFFE, 10'd4, 0);
        checks++; if (beats.size() != 4) begin errors++; $display("FAIL wrap_count got %0d exp 4", beats.size()); end
        for (int i = 0; i < beats.size() && i < 4; i++) begin
            checks++; if (beats[i] !== ex[i]) begin errors++; $display("FAIL wrap_beat%0d got %h exp %h", i, beats[i], ex[i]); end
        end
        tick();
        b_address_i = 16'h0100; b_len_i = 10'd0; b_start_i = 1'b1;
        tick();
        b_start_i = 1'b0;
        checks++; if (b_busy_o !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", b_busy_o); end
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            if (b_done_o || b_valid_o || b_busy_o) dones++;
            tick();
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL zero_activity got %0d exp 0", dones); end
    endtask

    task automatic test_back_to_back();
        burst(16'h0100, 10'd2, 0);
        checks++; if (done_cyc != 4) begin errors++; $display("FAIL b2b_first_done got %0d exp 4", done_cyc); end
        burst(16'h0104, 10'd2, 0);
        checks++; if (busy_start !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", busy_start); end
        checks++; if (beats.size() != 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", beats.size()); end
        if (beats.size() == 2) begin
            checks++; if (beats[0] !== 16'h0104 || beats[1] !== 16'h0105) begin errors++; $display("FAIL b2b_data got %h %h exp 0104 0105", beats[0], beats[1]); end
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        int dones;
        b_ready_i = 1'b1;
        b_address_i = 16'h0100; b_len_i = 10'd8; b_start_i = 1'b1;
        tick();
        b_start_i = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        checks++; if (b_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", b_valid_o); end
        checks++; if (b_busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", b_busy_o); end
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            if (b_done_o || b_valid_o) dones++;
            tick();
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL rst_mid_quiet got %0d exp 0", dones); end
        burst(16'h0104, 10'd4, 0);
        checks++; if (beats.size() != 4) begin errors++; $display("FAIL rst_after_count got %0d exp 4", beats.size()); end
        for (int i = 0; i < beats.size() && i < 4; i++) begin
            checks++; if (beats[i] !== 16'h0104 + 16'(i)) begin errors++; $display("FAIL rst_after_beat%0d got %h exp %h", i, beats[i], 16'h0104 + 16'(i)); end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_masked_write();
        test_read_first();
        test_full_throughput();
        test_backpressure();
        test_wrap_zero();
        test_back_to_back();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
